dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the memory-side end of the CPU's load/store port. It accepts one request at a time over a valid/ready handshake and performs byte, half or word loads and stores, little-endian, into an internal byte-addressed RAM. A programmable wait count models slow memory. It returns a one-cycle response with read data or a misalignment error. The pipeline's memory stage uses `req_ready`/`resp_valid` to generate its stall.

---
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Memory-side end of the CPU load/store port. Accepts one request
//            at a time over valid/ready, waits LATENCY cycles, then commits a
//            little-endian byte/half/word load or store to an internal
//            byte-addressed RAM and returns a one-cycle response.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            req_valid/req_ready       request handshake
//            req_we, req_size          store flag, RISC-V funct3 size code
//            req_addr, req_wdata       byte address, low-aligned store data
//            resp_valid                one-cycle response strobe
//            resp_rdata, resp_err      extended load data, error flag
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int LATENCY       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT     = 2'd1;
    localparam logic [1:0] c_RESP     = 2'd2;
    localparam bit         c_ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] c_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]               r_state;
    logic [3:0]               r_cnt;
    logic                     r_we;
    logic [2:0]               r_size;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_err;
    logic [7:0]               r_mem [0:(1 << ADDRESS_WIDTH)-1];

    logic                     w_idle;
    logic                     w_commit;
    logic                     w_we;
    logic [2:0]               w_size;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [7:0]               w_rbyte [4];
    logic [3:0]               w_bwe;
    logic                     w_misal;
    logic                     w_illegal;
    logic                     w_err;
    logic [DATA_WIDTH-1:0]    w_ld_data;
    logic                     w_unused;

    assign w_idle = (r_state == c_IDLE);

    // With zero latency the commit happens on the accept edge itself, so the
    // operands come straight from the request port rather than the latches.
    assign w_commit = (w_idle && req_valid && c_ZERO_LAT) ||
                      ((r_state == c_WAIT) && (r_cnt == 4'd0));
    assign w_we    = w_idle ? req_we                       : r_we;
    assign w_size  = w_idle ? req_size                     : r_size;
    assign w_addr  = w_idle ? req_addr[ADDRESS_WIDTH-1:0]  : r_addr;
    assign w_wdata = w_idle ? req_wdata                    : r_wdata;

    // Upper request-address bits are intentionally ignored.
    assign w_unused = ^req_addr[DATA_WIDTH-1:ADDRESS_WIDTH];

    // Four consecutive bytes starting at the access address; only aligned
    // accesses consume the upper ones, so the modulo wrap is harmless.
    for (genvar k = 0; k < 4; k++) begin : g_rd_byte
        assign w_rbyte[k] = r_mem[w_addr + ADDRESS_WIDTH'(k)];
    end

    always_comb begin
        w_bwe     = 4'b0000;
        w_ld_data = '0;
        case (w_size[1:0])
            2'b00:   w_bwe = 4'b0001;
            2'b01:   w_bwe = 4'b0011;
            2'b10:   w_bwe = 4'b1111;
            default: w_bwe = 4'b0000;
        endcase
        w_misal   = ((w_size[1:0] == 2'b01) && w_addr[0]) ||
                    ((w_size == 3'b010) && (w_addr[1:0] != 2'b00));
        w_illegal = (w_size == 3'b011) || (w_size == 3'b110) ||
                    (w_size == 3'b111) || (w_we && w_size[2]);
        w_err     = w_misal || w_illegal;
        case (w_size)
            3'b000:  w_ld_data = {{(DATA_WIDTH-8){w_rbyte[0][7]}}, w_rbyte[0]};
            3'b001:  w_ld_data = {{(DATA_WIDTH-16){w_rbyte[1][7]}}, w_rbyte[1], w_rbyte[0]};
            3'b010:  w_ld_data = {w_rbyte[3], w_rbyte[2], w_rbyte[1], w_rbyte[0]};
            3'b100:  w_ld_data = {{(DATA_WIDTH-8){1'b0}}, w_rbyte[0]};
            3'b101:  w_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_rbyte[1], w_rbyte[0]};
            default: w_ld_data = '0;
        endcase
    end

    // RAM is not reset; reset only blocks a commit landing on the same edge.
    always_ff @(posedge clk) begin
        if (w_commit && !rst && w_we && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_bwe[k]) begin
                    r_mem[w_addr + ADDRESS_WIDTH'(k)] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_addr  <= req_addr[ADDRESS_WIDTH-1:0];
                        r_wdata <= req_wdata;
                        if (c_ZERO_LAT) begin
                            r_state <= c_RESP;
                        end else begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase

            // Response payload lives only for the single RESP cycle.
            if (w_commit) begin
                r_rdata <= (w_err || w_we) ? '0 : w_ld_data;
                r_err   <= w_err;
            end else begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign req_ready  = w_idle;
    assign resp_valid = (r_state == c_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. Three instances with
//            LATENCY 2, 0 and 4 share one clock; directed vectors, hand-made
//            multi-cycle sequences and a randomized run against a byte-array
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_N = 3;

    logic        clk = 1'b0;
    logic        rst        [c_N];
    logic        req_valid  [c_N];
    logic        req_we     [c_N];
    logic [2:0]  req_size   [c_N];
    logic [31:0] req_addr   [c_N];
    logic [31:0] req_wdata  [c_N];
    logic        req_ready  [c_N];
    logic        resp_valid [c_N];
    logic [31:0] resp_rdata [c_N];
    logic        resp_err   [c_N];

    int total = 0;
    int bad   = 0;

    bit [7:0] mdl [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_N; g++) begin : g_dut
        dmem_responder #(
            .ADDRESS_WIDTH(16),
            .DATA_WIDTH   (32),
            .LATENCY      ((g == 0) ? 2 : ((g == 1) ? 0 : 4))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_we    (req_we[g]),
            .req_size  (req_size[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_ready (req_ready[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference model: plain byte array, sizes and rules straight from the
    // load/store definition.
    task automatic model(input bit we, input bit [2:0] sz, input bit [31:0] a,
                         input bit [31:0] wd, output bit [31:0] rd, output bit er);
        int     nb;
        int     base;
        longint v;
        base = int'(a & 32'hFFFF);
        case (sz)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    nb = 0;
        endcase
        er = (nb == 0) || (we && sz > 3'd3) || ((nb > 0) && (base % nb != 0));
        rd = 32'h0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mdl[base + i] = 8'(wd >> (8 * i));
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v += longint'(mdl[base + i]) << (8 * i);
            if (sz < 3'd4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v -= (longint'(1) << (8 * nb));
            rd = 32'(v);
        end
    endtask

    // Call just after a negedge. Returns with the bench on the negedge after
    // the response cycle; n = number of negedges from acceptance to response.
    task automatic xact(input int k, input bit we, input bit [2:0] sz, input bit [31:0] a,
                        input bit [31:0] wd, output bit [31:0] rd, output bit er, output int n);
        int guard;
        bit busy_hi;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_size[k]  = sz;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        guard = 0;
        while (req_ready[k] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("ready_timeout", 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_we[k]    = 1'($urandom);
        req_size[k]  = 3'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        n       = 0;
        busy_hi = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (req_ready[k] !== 1'b0) busy_hi = 1'b1;
        end while (resp_valid[k] !== 1'b1 && n < 40);
        rd = resp_rdata[k];
        er = resp_err[k];
        chk("ready_low_while_busy", 32'(busy_hi), 32'd0);
        @(negedge clk);
        chk("post_resp_valid", 32'(resp_valid[k]), 32'd0);
        chk("post_resp_rdata", resp_rdata[k], 32'd0);
        chk("post_resp_err",   32'(resp_err[k]), 32'd0);
        chk("post_resp_ready", 32'(req_ready[k]), 32'd1);
    endtask

    typedef struct {
        bit        we;
        bit [2:0]  sz;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] rd;
        bit        err;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t      tbl [$];
        bit [31:0] rd, erd;
        bit        er, eer;
        int        n;
        bit        seen;
        bit        we;
        bit [2:0]  sz;
        bit [31:0] a, wd;

        for (int k = 0; k < c_N; k++) begin
            rst[k]       = 1'b1;
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_size[k]  = 3'b000;
            req_addr[k]  = 32'h0;
            req_wdata[k] = 32'h0;
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < c_N; k++) begin
            chk($sformatf("reset_ready%0d", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("reset_valid%0d", k), 32'(resp_valid[k]), 32'd0);
            chk($sformatf("reset_rdata%0d", k), resp_rdata[k], 32'd0);
            chk($sformatf("reset_err%0d", k),   32'(resp_err[k]), 32'd0);
            rst[k] = 1'b0;
        end
        @(negedge clk);

        // Directed vectors on the LATENCY=2 instance.
        tbl.push_back('{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0});
        tbl.push_back('{1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0});
        tbl.push_back('{1'b0, 3'b001, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 1'b0});
        tbl.push_back('{1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0});
        tbl.push_back('{1'b1, 3'b000, 32'h0000_0011, 32'h1234_5678, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_78EF, 1'b0});
        tbl.push_back('{1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1});
        tbl.push_back('{1'b1, 3'b001, 32'h0000_0021, 32'h0000_AAAA, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b0, 3'b011, 32'h0000_0020, 32'h0,         32'h0000_0000, 1'b1});
        tbl.push_back('{1'b1, 3'b100, 32'h0000_0020, 32'h0000_00FF, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b1, 3'b111, 32'h0000_0020, 32'h0000_00FF, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'h1122_3344, 1'b0});
        tbl.push_back('{1'b0, 3'b010, 32'hABCD_0020, 32'h0,         32'h1122_3344, 1'b0});
        tbl.push_back('{1'b0, 3'b001, 32'h0000_0022, 32'h0,         32'h0000_1122, 1'b0});
        tbl.push_back('{1'b0, 3'b000, 32'h0000_0021, 32'h0,         32'h0000_0033, 1'b0});

        foreach (tbl[i]) begin
            xact(0, tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd, rd, er, n);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_err", i),   32'(er), 32'(tbl[i].err));
            chk($sformatf("vec%0d_lat", i),   32'(n), 32'(lat_of(0) + 1));
        end

        // Randomized run in window 0x100..0x13F, prefilled through the port.
        for (int w = 0; w < 16; w++) begin
            a  = 32'h100 + 32'(4 * w);
            wd = $urandom;
            model(1'b1, 3'b010, a, wd, erd, eer);
            xact(0, 1'b1, 3'b010, a, wd, rd, er, n);
            chk("fill_err", 32'(er), 32'(eer));
        end
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            a  = (32'h100 + 32'($urandom_range(0, 63))) | ($urandom & 32'hFFFF_0000);
            wd = $urandom;
            model(we, sz, a, wd, erd, eer);
            xact(0, we, sz, a, wd, rd, er, n);
            chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_err", i),   32'(er), 32'(eer));
            chk($sformatf("rnd%0d_lat", i),   32'(n), 32'(lat_of(0) + 1));
        end

        // LATENCY=0: request held valid, acceptance every second cycle.
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_size[1]  = 3'b010;
        req_addr[1]  = 32'h30;
        req_wdata[1] = 32'hA5A5_A5A5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("lat0_ready%0d", i), 32'(req_ready[1]),  32'(i % 2));
            chk($sformatf("lat0_valid%0d", i), 32'(resp_valid[1]), 32'((i + 1) % 2));
            if (i % 2 == 0) chk($sformatf("lat0_err%0d", i), 32'(resp_err[1]), 32'd0);
        end
        req_valid[1] = 1'b0;
        xact(1, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, n);
        chk("lat0_load_rdata", rd, 32'hA5A5_A5A5);
        chk("lat0_load_lat",   32'(n), 32'd1);

        // LATENCY=4: reset two cycles after accepting a store cancels it.
        xact(2, 1'b1, 3'b010, 32'h40, 32'h0102_0304, rd, er, n);
        chk("lat4_store_err", 32'(er), 32'd0);
        chk("lat4_store_lat", 32'(n), 32'd5);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_size[2]  = 3'b010;
        req_addr[2]  = 32'h40;
        req_wdata[2] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        chk("rst_mid_ready", 32'(req_ready[2]), 32'd1);
        chk("rst_mid_valid", 32'(resp_valid[2]), 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[2] !== 1'b0) seen = 1'b1;
        end
        chk("rst_mid_no_resp", 32'(seen), 32'd0);
        xact(2, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, n);
        chk("rst_mid_old_data", rd, 32'h0102_0304);
        chk("rst_mid_load_lat", 32'(n), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
